// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and edge-detect one asynchronous input.
// Optional rejected-glitch counter: define INPUT_CONDITIONER_GLITCH_CNT_EN.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       clean_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       stable
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic {STABLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   stable_q, stable_d;
  logic                   mismatch;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  logic [7:0]             glitch_q, glitch_d;
`endif

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync_s != clean_q);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    state_d  = state_q;
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    glitch_d = glitch_q;
`endif
    case (state_q)
      STABLE: begin
        if (mismatch) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      default: begin
        if (!mismatch) begin
          // Input fell back before the debounce window filled: glitch rejected.
          state_d = STABLE;
          cnt_d   = '0;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          clean_d = ~clean_q;
          rise_d  = ~clean_q;
          fall_d  = clean_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
    stable_d = (state_d == STABLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= STABLE;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
      glitch_q <= '0;
`endif
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign stable     = stable_q;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream conditioning stage for the sequential and latch stages.
- Takes one asynchronous raw input (switch or external pin). Synchronises it, debounces it, and produces:
  - a clean level that drives the flop data input `d` or the latch enable;
  - single-cycle rise and fall pulses for downstream edge-triggered logic.
- One clock domain. All outputs are registered.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchroniser chain; legal values >= 2.
- DEBOUNCE_CYCLES, 4, number of consecutive mismatching samples required before `clean_out` changes; legal values >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of the debounce counter; derived, do not override.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  1  asynchronous raw input.
- clean_out  output  1  debounced, synchronised level.
- rise_pulse  output  1  high for one cycle when `clean_out` goes 0->1.
- fall_pulse  output  1  high for one cycle when `clean_out` goes 1->0.
- stable  output  1  high when the FSM is in STABLE (no transition pending).

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset (sampled at a rising `clk` edge while `reset`=1):
  - all synchroniser flops = 0;
  - `clean_out`=0, `rise_pulse`=0, `fall_pulse`=0;
  - counter = 0, state = STABLE, so `stable`=1.
- Reset overrides all other activity. Reset asserted mid-CHECK returns the FSM to STABLE, clears the counter, and produces no pulse.
- Synchroniser: a SYNC_STAGES-deep flop chain. Its last stage is `sync_s`. No logic sits between stages.
- FSM states: STABLE, CHECK.
- STABLE:
  - `sync_s` == `clean_out`: stay in STABLE, counter = 0.
  - `sync_s` != `clean_out`: go to CHECK, counter <= 1.
- CHECK:
  - `sync_s` == `clean_out` (glitch rejected): go to STABLE, counter <= 0, `clean_out` unchanged.
  - Mismatch and counter == DEBOUNCE_CYCLES-1: `clean_out` <= ~`clean_out`, counter <= 0, go to STABLE.
  - Mismatch otherwise: counter <= counter+1.
- Latency: edge 1 is the first rising edge that samples a new `raw_in` value. A `raw_in` change held steady updates `clean_out` at edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 6.
- Glitch rejection: a `raw_in` level held for fewer than DEBOUNCE_CYCLES consecutive `sync_s` samples never reaches `clean_out`.
- Pulses:
  - registered in the same edge that toggles `clean_out`;
  - `rise_pulse`=1 exactly in the first cycle that `clean_out`=1;
  - `fall_pulse`=1 exactly in the first cycle that `clean_out`=0;
  - both pulses are never high together;
  - both are 0 in every other cycle.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Counter reset by an opposite sample: a mismatch run interrupted by one matching sample restarts from counter = 1 on the next mismatch.
- Elaboration checks: SYNC_STAGES<2 or DEBOUNCE_CYCLES<2 triggers an elaboration-time `$error`.

Optional Feature:
- Macro: INPUT_CONDITIONER_GLITCH_CNT_EN.
- When defined:
  - adds output port `glitch_cnt`  output  8;
  - the counter increments on every CHECK->STABLE transition taken without a toggle (rejected glitch);
  - it saturates at 255 and holds;
  - reset sets it to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: `reset`=1 for 3 cycles with `raw_in`=1, then `reset`=0. Required: `clean_out`=0, `stable`=1, no pulses during reset, and `clean_out` rises at edge 6 after release.
- Clean rise, defaults: `raw_in` 0->1 held steady. Required: `clean_out`=1 from edge 6; `rise_pulse`=1 for exactly one cycle at edge 6; `stable`=0 during edges 3-5.
- Glitch: `raw_in`=1 for 3 cycles, then 0. Required: `clean_out` stays 0, no pulses, and `stable` returns to 1. With the feature enabled, `glitch_cnt`=1.
- Clean fall: from `clean_out`=1, `raw_in` 1->0 held steady. Required: `clean_out`=0 at edge 6; `fall_pulse` high for one cycle; `rise_pulse` stays 0.
- Reset mid-CHECK: start a rise, assert `reset` at edge 4 for 1 cycle. Required: `clean_out`=0, no `rise_pulse`, counter = 0. With `raw_in` still 1, `clean_out` rises 6 edges after release.
- Saturation (feature enabled): 300 glitches of 2 cycles each, separated by 8 idle cycles. Required: `glitch_cnt`=255 and held; `clean_out` remains 0 throughout.
